// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller.
// Holds the front-end FSM state encoding, the hard-wired zero register
// number, and the default mul/div latency plus the width of its busy counter.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    LOAD_BR = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MD_LATENCY_DEFAULT = 32;

  // Wide enough for the largest legal latency (255).
  localparam int MD_CNT_W = 8;

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Busy counter for the multi-cycle mul/div unit.
// Loads MD_LATENCY on a start and counts down to zero; busy while nonzero.
// Ports:
//   clk_i   - core clock, rising edge
//   rst_i   - asynchronous active-high reset, abandons any in-flight operation
//   start_i - mul/div launched this cycle
//   busy_o  - counter nonzero
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic busy_o
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LATENCY);

  logic [MD_CNT_W-1:0] cnt_q;
  logic [MD_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core (branches resolved in ID).
// Detects load-use, branch-operand and mul/div occupancy hazards, stalls the
// front end and inserts bubbles, and flushes IF/ID on taken branches/jumps.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   IF_ID_* / ID_*        - decoded fields of the instruction in ID
//   ID_EX_* / EX_MEM_*    - destination/type info of instructions in EX and MEM
//   PC_Write, IF_ID_Write - front-end enables (low while stalled)
//   IF_ID_Flush           - squash the fetched instruction after a redirect
//   ID_EX_Flush           - bubble into EX while stalled
//   MD_start, MD_busy     - mul/div launch and occupancy
//   stall_cycles, flush_count - free-running wrap-around event counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           IF_ID_rs,
  input  logic [4:0]           IF_ID_rt,
  input  logic                 ID_uses_rs,
  input  logic                 ID_uses_rt,
  input  logic                 ID_Branch,
  input  logic                 ID_Jump,
  input  logic                 Branch_taken,
  input  logic                 ID_MulDiv,
  input  logic                 ID_ReadHiLo,
  input  logic [4:0]           ID_EX_Write_register,
  input  logic                 ID_EX_RegWrite,
  input  logic                 ID_EX_MemRead,
  input  logic [4:0]           EX_MEM_Write_register,
  input  logic                 EX_MEM_MemRead,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic                 MD_start,
  output logic                 MD_busy,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  state_e state_q;
  state_e state_d;

  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  logic hit_ex;
  logic hit_mem;
  logic load_use;
  logic br_alu;
  logic br_ld_mem;
  logic md_hz;
  logic stall;
  logic redirect;
  logic md_busy_w;

  // Does a producer's destination feed an operand the ID instruction reads?
  // $zero is hard-wired, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic use_rs,
                                   input logic use_rt);
    return (dst != REG_ZERO) && ((use_rs && (dst == rs)) || (use_rt && (dst == rt)));
  endfunction

  assign hit_ex  = reg_hit(ID_EX_Write_register, IF_ID_rs, IF_ID_rt, ID_uses_rs, ID_uses_rt);
  assign hit_mem = reg_hit(EX_MEM_Write_register, IF_ID_rs, IF_ID_rt, ID_uses_rs, ID_uses_rt);

  assign load_use  = ID_EX_MemRead && hit_ex;
  assign br_alu    = ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && hit_ex;
  assign br_ld_mem = ID_Branch && EX_MEM_MemRead && hit_mem;
  assign md_hz     = (ID_MulDiv || ID_ReadHiLo) && md_busy_w;

  // Gating with reset keeps the front end running with no flushes or starts
  // while reset is held, independent of whatever the decode inputs show.
  assign stall    = !reset && (load_use || br_alu || br_ld_mem || md_hz || (state_q == LOAD_BR));
  assign redirect = !reset && !stall && (ID_Jump || (ID_Branch && Branch_taken));

  // A branch behind a load needs its operand from MEM, one cycle later than
  // an ordinary load-use; LOAD_BR holds the extra stall cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (ID_Branch && load_use) state_d = LOAD_BR;
      LOAD_BR: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (redirect) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  md_busy_counter #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_busy (
    .clk_i  (clk),
    .rst_i  (reset),
    .start_i(MD_start),
    .busy_o (md_busy_w)
  );

  assign PC_Write     = !stall;
  assign IF_ID_Write  = !stall;
  assign ID_EX_Flush  = stall;
  assign IF_ID_Flush  = redirect;
  assign MD_start     = !reset && ID_MulDiv && !stall;
  assign MD_busy      = md_busy_w;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  IF_ID_rs = '0;
  logic [4:0]  IF_ID_rt = '0;
  logic        ID_uses_rs = 1'b0;
  logic        ID_uses_rt = 1'b0;
  logic        ID_Branch = 1'b0;
  logic        ID_Jump = 1'b0;
  logic        Branch_taken = 1'b0;
  logic        ID_MulDiv = 1'b0;
  logic        ID_ReadHiLo = 1'b0;
  logic [4:0]  ID_EX_Write_register = '0;
  logic        ID_EX_RegWrite = 1'b0;
  logic        ID_EX_MemRead = 1'b0;
  logic [4:0]  EX_MEM_Write_register = '0;
  logic        EX_MEM_MemRead = 1'b0;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        MD_start;
  logic        MD_busy;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(
    .MD_LATENCY(LAT),
    .CNT_WIDTH (32)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .IF_ID_rs             (IF_ID_rs),
    .IF_ID_rt             (IF_ID_rt),
    .ID_uses_rs           (ID_uses_rs),
    .ID_uses_rt           (ID_uses_rt),
    .ID_Branch            (ID_Branch),
    .ID_Jump              (ID_Jump),
    .Branch_taken         (Branch_taken),
    .ID_MulDiv            (ID_MulDiv),
    .ID_ReadHiLo          (ID_ReadHiLo),
    .ID_EX_Write_register (ID_EX_Write_register),
    .ID_EX_RegWrite       (ID_EX_RegWrite),
    .ID_EX_MemRead        (ID_EX_MemRead),
    .EX_MEM_Write_register(EX_MEM_Write_register),
    .EX_MEM_MemRead       (EX_MEM_MemRead),
    .PC_Write             (PC_Write),
    .IF_ID_Write          (IF_ID_Write),
    .IF_ID_Flush          (IF_ID_Flush),
    .ID_EX_Flush          (ID_EX_Flush),
    .MD_start             (MD_start),
    .MD_busy              (MD_busy),
    .stall_cycles         (stall_cycles),
    .flush_count          (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending second stall of a branch behind a load, cycles of mul/div left,
  // and running event totals.
  bit      m_second_stall = 1'b0;
  int      m_md_left = 0;
  int      m_stalls = 0;
  int      m_flushes = 0;

  function automatic bit reads_reg(input logic [4:0] r);
    return (r != 5'd0) && ((ID_uses_rs && r == IF_ID_rs) || (ID_uses_rt && r == IF_ID_rt));
  endfunction

  always @(negedge clk) begin
    bit from_ex, from_mem, lu, st, fl, go;
    if (reset) begin
      chk("rst_pc_write", {31'd0, PC_Write}, 32'd1);
      chk("rst_ifid_write", {31'd0, IF_ID_Write}, 32'd1);
      chk("rst_ifid_flush", {31'd0, IF_ID_Flush}, 32'd0);
      chk("rst_idex_flush", {31'd0, ID_EX_Flush}, 32'd0);
      chk("rst_md_start", {31'd0, MD_start}, 32'd0);
      chk("rst_md_busy", {31'd0, MD_busy}, 32'd0);
      chk("rst_stall_cycles", stall_cycles, 32'd0);
      chk("rst_flush_count", flush_count, 32'd0);
      m_second_stall = 1'b0;
      m_md_left = 0;
      m_stalls = 0;
      m_flushes = 0;
    end else begin
      from_ex  = reads_reg(ID_EX_Write_register);
      from_mem = reads_reg(EX_MEM_Write_register);
      lu = ID_EX_MemRead && from_ex;
      st = m_second_stall || lu
           || (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && from_ex)
           || (ID_Branch && EX_MEM_MemRead && from_mem)
           || ((ID_MulDiv || ID_ReadHiLo) && m_md_left > 0);
      fl = !st && (ID_Jump || (ID_Branch && Branch_taken));
      go = ID_MulDiv && !st;
      chk("pc_write", {31'd0, PC_Write}, {31'd0, !st});
      chk("ifid_write", {31'd0, IF_ID_Write}, {31'd0, !st});
      chk("idex_flush", {31'd0, ID_EX_Flush}, {31'd0, st});
      chk("ifid_flush", {31'd0, IF_ID_Flush}, {31'd0, fl});
      chk("md_start", {31'd0, MD_start}, {31'd0, go});
      chk("md_busy", {31'd0, MD_busy}, {31'd0, m_md_left > 0});
      chk("stall_cycles", stall_cycles, 32'(m_stalls));
      chk("flush_count", flush_count, 32'(m_flushes));
      m_second_stall = !m_second_stall && ID_Branch && lu;
      if (go) m_md_left = LAT;
      else if (m_md_left > 0) m_md_left--;
      if (st) m_stalls++;
      if (fl) m_flushes++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    IF_ID_rs = '0; IF_ID_rt = '0; ID_uses_rs = 0; ID_uses_rt = 0;
    ID_Branch = 0; ID_Jump = 0; Branch_taken = 0; ID_MulDiv = 0; ID_ReadHiLo = 0;
    ID_EX_Write_register = '0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0;
    EX_MEM_Write_register = '0; EX_MEM_MemRead = 0;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic ex_load(input logic [4:0] r);
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Write_register = r;
  endtask

  initial begin
    idle();
    #1;
    chk("lit_reset_pc", {31'd0, PC_Write}, 32'd1);
    chk("lit_reset_busy", {31'd0, MD_busy}, 32'd0);
    // Hazards and redirects presented during reset must be ignored.
    ex_load(5'd8); ID_uses_rs = 1; IF_ID_rs = 5'd8; ID_Jump = 1; ID_MulDiv = 1;
    #1;
    chk("lit_reset_hz_pc", {31'd0, PC_Write}, 32'd1);
    chk("lit_reset_hz_flush", {31'd0, IF_ID_Flush}, 32'd0);
    chk("lit_reset_hz_start", {31'd0, MD_start}, 32'd0);
    adv(); adv();
    reset = 0; idle();
    mid(); adv();

    // load-use: lw $8 in EX, add reads $8
    idle(); ex_load(5'd8); ID_uses_rs = 1; IF_ID_rs = 5'd8;
    mid();
    chk("lit_lu_pc", {31'd0, PC_Write}, 32'd0);
    chk("lit_lu_bubble", {31'd0, ID_EX_Flush}, 32'd1);
    adv();
    idle(); EX_MEM_MemRead = 1; EX_MEM_Write_register = 5'd8; ID_uses_rs = 1; IF_ID_rs = 5'd8;
    mid();
    chk("lit_lu_release", {31'd0, PC_Write}, 32'd1);
    chk("lit_lu_count", stall_cycles, 32'd1);
    adv();

    // $zero never hazards
    idle(); ex_load(5'd0); ID_uses_rs = 1; IF_ID_rs = 5'd0;
    mid();
    chk("lit_zero_pc", {31'd0, PC_Write}, 32'd1);
    adv();

    // beq behind lw $9: two stall cycles, then taken branch flushes
    idle(); ex_load(5'd9); ID_Branch = 1; ID_uses_rs = 1; IF_ID_rs = 5'd3; ID_uses_rt = 1; IF_ID_rt = 5'd9;
    mid();
    chk("lit_ldbr1_pc", {31'd0, PC_Write}, 32'd0);
    adv();
    idle(); ID_Branch = 1; ID_uses_rs = 1; IF_ID_rs = 5'd3; ID_uses_rt = 1; IF_ID_rt = 5'd9; Branch_taken = 1;
    mid();
    chk("lit_ldbr2_pc", {31'd0, PC_Write}, 32'd0);
    chk("lit_ldbr2_noflush", {31'd0, IF_ID_Flush}, 32'd0);
    adv();
    mid();
    chk("lit_ldbr_taken_flush", {31'd0, IF_ID_Flush}, 32'd1);
    chk("lit_ldbr_stalls", stall_cycles, 32'd3);
    adv();
    idle();
    mid();
    chk("lit_flush_count1", flush_count, 32'd1);
    adv();

    // branch on ALU result in EX
    idle(); ID_EX_RegWrite = 1; ID_EX_Write_register = 5'd5; ID_Branch = 1; ID_uses_rs = 1; IF_ID_rs = 5'd5;
    mid();
    chk("lit_bralu_stall", {31'd0, ID_EX_Flush}, 32'd1);
    adv();
    idle(); EX_MEM_Write_register = 5'd5; ID_Branch = 1; ID_uses_rs = 1; IF_ID_rs = 5'd5;
    mid(); adv();
    idle(); ID_EX_RegWrite = 1; ID_EX_Write_register = 5'd5; ID_uses_rs = 1; IF_ID_rs = 5'd5;
    mid();
    chk("lit_alu_nobranch", {31'd0, PC_Write}, 32'd1);
    adv();

    // mult then mflo waits out the unit
    idle(); ID_MulDiv = 1;
    mid();
    chk("lit_mult_start", {31'd0, MD_start}, 32'd1);
    adv();
    for (int i = 0; i < LAT; i++) begin
      idle(); ID_ReadHiLo = 1;
      mid();
      chk("lit_mflo_wait", {31'd0, PC_Write}, 32'd0);
      chk("lit_mflo_busy", {31'd0, MD_busy}, 32'd1);
      adv();
    end
    idle(); ID_ReadHiLo = 1;
    mid();
    chk("lit_mflo_issue", {31'd0, PC_Write}, 32'd1);
    chk("lit_mflo_stalls", stall_cycles, 32'd8);
    adv();

    // second mult arriving when the count is at 1 waits one cycle
    idle(); ID_MulDiv = 1; mid(); adv();
    idle(); for (int i = 0; i < LAT - 1; i++) begin mid(); adv(); end
    ID_MulDiv = 1;
    mid();
    chk("lit_md_edge_hold", {31'd0, MD_start}, 32'd0);
    adv();
    mid();
    chk("lit_md_edge_go", {31'd0, MD_start}, 32'd1);
    adv();
    idle(); for (int i = 0; i < LAT; i++) begin mid(); adv(); end

    // jump, then jump colliding with a load-use
    idle(); ID_Jump = 1;
    mid();
    chk("lit_jump_flush", {31'd0, IF_ID_Flush}, 32'd1);
    chk("lit_jump_pc", {31'd0, PC_Write}, 32'd1);
    adv();
    idle(); ID_Jump = 1; ex_load(5'd7); ID_uses_rt = 1; IF_ID_rt = 5'd7;
    mid();
    chk("lit_jump_lu_noflush", {31'd0, IF_ID_Flush}, 32'd0);
    chk("lit_jump_lu_pc", {31'd0, PC_Write}, 32'd0);
    adv();
    idle();
    mid();
    chk("lit_totals_flush", flush_count, 32'd2);
    chk("lit_totals_stall", stall_cycles, 32'd10);
    adv();

    // reset while in LOAD_BR with three mul/div cycles remaining
    idle(); ID_MulDiv = 1; mid(); adv();
    idle(); ex_load(5'd9); ID_Branch = 1; ID_uses_rt = 1; IF_ID_rt = 5'd9; mid(); adv();
    idle(); ID_Branch = 1; ID_uses_rt = 1; IF_ID_rt = 5'd9;
    mid();
    chk("lit_prerst_pc", {31'd0, PC_Write}, 32'd0);
    chk("lit_prerst_busy", {31'd0, MD_busy}, 32'd1);
    reset = 1;
    #1;
    chk("lit_async_pc", {31'd0, PC_Write}, 32'd1);
    chk("lit_async_busy", {31'd0, MD_busy}, 32'd0);
    chk("lit_async_stalls", stall_cycles, 32'd0);
    chk("lit_async_flushes", flush_count, 32'd0);
    adv(); mid(); adv();
    reset = 0;
    mid();
    chk("lit_postrst_run", {31'd0, PC_Write}, 32'd1);
    chk("lit_postrst_stalls", stall_cycles, 32'd0);
    adv();
    idle(); mid(); adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
